// File: rtl/time_pkg.sv
// Shared definitions for the BCD time word (mm:ss.mmm) and the BCD-to-ticks converter.
package time_pkg;

  localparam int TIME_W  = 32;
  localparam int FIELD_W = 28;

  localparam int MS_LSB  = 0;
  localparam int MS_W    = 12;
  localparam int SEC_LSB = 12;
  localparam int SEC_W   = 8;
  localparam int MIN_LSB = 20;
  localparam int MIN_W   = 8;

  localparam int TICKS_PER_MS    = 100000;
  localparam int OUT_W_DEF       = 39;
  localparam int TICK_DIGITS_DEF = 5;

  localparam logic [OUT_W_DEF-1:0] SAT_TICKS = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } conv_state_e;

  function automatic logic bcd_digit_ok(input logic [3:0] d);
    return d <= 4'd9;
  endfunction

  // Seconds tens digit is limited to 0..5; every other digit to 0..9.
  function automatic logic time_word_valid(input logic [FIELD_W-1:0] t);
    logic ok;
    ok = bcd_digit_ok(t[MIN_LSB+4 +: 4]) &&
         bcd_digit_ok(t[MIN_LSB   +: 4]) &&
         (t[SEC_LSB+4 +: 4] <= 4'd5)    &&
         bcd_digit_ok(t[SEC_LSB   +: 4]) &&
         bcd_digit_ok(t[MS_LSB+8  +: 4]) &&
         bcd_digit_ok(t[MS_LSB+4  +: 4]) &&
         bcd_digit_ok(t[MS_LSB    +: 4]);
    return ok;
  endfunction

endpackage

// File: rtl/bcd_digit_mac.sv
// Combinational multiply-accumulate step: acc * (6 or 10) + digit using shifts and adds only.
module bcd_digit_mac #(
  parameter int ACC_W = 40
) (
  input  logic [ACC_W-1:0] acc_in,
  input  logic [3:0]       digit,
  input  logic             mul6,
  output logic [ACC_W-1:0] acc_out
);

  logic [ACC_W-1:0] times2;
  logic [ACC_W-1:0] scaled;

  always_comb begin
    times2  = acc_in << 1;
    scaled  = mul6 ? ((acc_in << 2) + times2) : ((acc_in << 3) + times2);
    acc_out = scaled + ACC_W'(digit);
  end

endmodule

// File: rtl/bcd_time_to_ticks.sv
// Converts a packed BCD time mm:ss.mmm into a count of 10 ns ticks, one digit per clock,
// with input validation and saturation on overflow of the output width.
module bcd_time_to_ticks
  import time_pkg::*;
#(
  parameter int OUT_W       = OUT_W_DEF,
  parameter int TICK_DIGITS = TICK_DIGITS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [TIME_W-1:0] time_bcd,
  output logic              busy,
  output logic              done,
  output logic [OUT_W-1:0]  ticks_out,
  output logic              err,
  output logic              ovf
);

  localparam int ACC_W   = OUT_W + 1;
  localparam int N_STEPS = 7 + TICK_DIGITS;
  localparam int STEP_W  = $clog2(N_STEPS);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_STEPS - 1);

  conv_state_e        state_q, state_d;
  logic [FIELD_W-1:0] time_q, time_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [OUT_W-1:0]   ticks_q, ticks_d;
  logic               err_q, err_d;
  logic               ovf_q, ovf_d;

  logic [3:0]       digit;
  logic             mul6;
  logic [ACC_W-1:0] mac_out;
  logic             unused_top_nibble;

  assign unused_top_nibble = ^time_bcd[TIME_W-1:FIELD_W];

  // Digit feeding each step; the trailing steps append zeros to scale ms to ticks.
  always_comb begin
    digit = 4'd0;
    mul6  = 1'b0;
    case (step_q)
      STEP_W'(0): digit = time_q[MIN_LSB+4 +: 4];
      STEP_W'(1): digit = time_q[MIN_LSB   +: 4];
      STEP_W'(2): begin
        digit = time_q[SEC_LSB+4 +: 4];
        mul6  = 1'b1;
      end
      STEP_W'(3): digit = time_q[SEC_LSB   +: 4];
      STEP_W'(4): digit = time_q[MS_LSB+8  +: 4];
      STEP_W'(5): digit = time_q[MS_LSB+4  +: 4];
      STEP_W'(6): digit = time_q[MS_LSB    +: 4];
      default:    digit = 4'd0;
    endcase
  end

  bcd_digit_mac #(
    .ACC_W (ACC_W)
  ) u_mac (
    .acc_in  (acc_q),
    .digit   (digit),
    .mul6    (mul6),
    .acc_out (mac_out)
  );

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    acc_d   = acc_q;
    step_d  = step_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ticks_d = ticks_q;
    err_d   = err_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          time_d = time_bcd[FIELD_W-1:0];
          acc_d  = '0;
          step_d = '0;
          err_d  = 1'b0;
          ovf_d  = 1'b0;
          if (time_word_valid(time_bcd[FIELD_W-1:0])) begin
            state_d = ST_RUN;
            busy_d  = 1'b1;
          end else begin
            state_d = ST_ERR;
          end
        end
      end

      // Invalid input still answers one cycle later so callers see a uniform handshake.
      ST_ERR: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        err_d   = 1'b1;
        ovf_d   = 1'b0;
        ticks_d = '0;
      end

      ST_RUN: begin
        acc_d = mac_out;
        if (step_q == LAST_STEP) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          step_d  = '0;
          err_d   = 1'b0;
          if (mac_out[OUT_W]) begin
            ticks_d = '1;
            ovf_d   = 1'b1;
          end else begin
            ticks_d = mac_out[OUT_W-1:0];
            ovf_d   = 1'b0;
          end
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      time_q  <= '0;
      acc_q   <= '0;
      step_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ticks_q <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      acc_q   <= acc_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ticks_q <= ticks_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign ticks_out = ticks_q;
  assign err       = err_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_bcd_time_to_ticks.sv
// Self-checking bench for bcd_time_to_ticks: vector table, scoreboard queue, handshake corner cases.
module tb_bcd_time_to_ticks;

  localparam int OUT_W = 39;
  localparam longint MAX_TICKS = 64'd549_755_813_887;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [31:0]      time_bcd;
  logic             busy;
  logic             done;
  logic [OUT_W-1:0] ticks_out;
  logic             err;
  logic             ovf;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  int     done_count = 0;

  typedef struct {
    logic [31:0] t;
    longint      ticks;
    bit          err;
    bit          ovf;
  } vec_t;

  typedef struct {
    longint ticks;
    bit     err;
    bit     ovf;
    int     lat;
    longint start_cyc;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[13];

  bcd_time_to_ticks #(
    .OUT_W       (OUT_W),
    .TICK_DIGITS (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .time_bcd  (time_bcd),
    .busy      (busy),
    .done      (done),
    .ticks_out (ticks_out),
    .err       (err),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (done) done_count <= done_count + 1;

  function automatic logic [31:0] packTime(input int m, input int s, input int ms);
    return {4'd0, 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
            4'(ms / 100), 4'((ms / 10) % 10), 4'(ms % 10)};
  endfunction

  // Reference arithmetic: decimal value of each field, scaled to 10 ns ticks.
  function automatic void refModel(input logic [31:0] t, output longint ticks,
                                   output bit e, output bit o);
    int d[7];
    longint val;
    d[0] = int'(t[27:24]); d[1] = int'(t[23:20]);
    d[2] = int'(t[19:16]); d[3] = int'(t[15:12]);
    d[4] = int'(t[11:8]);  d[5] = int'(t[7:4]);  d[6] = int'(t[3:0]);
    e = 1'b0;
    o = 1'b0;
    ticks = 0;
    for (int k = 0; k < 7; k++) if (d[k] > 9) e = 1'b1;
    if (d[2] > 5) e = 1'b1;
    if (!e) begin
      val = ((longint'(d[0] * 10 + d[1]) * 60 + longint'(d[2] * 10 + d[3])) * 1000
             + longint'(d[4] * 100 + d[5] * 10 + d[6])) * 100000;
      if (val > MAX_TICKS) begin
        ticks = MAX_TICKS;
        o = 1'b1;
      end else begin
        ticks = val;
      end
    end
  endfunction

  // Display-path model: ticks back to packed BCD mm:ss.mmm.
  function automatic logic [31:0] ticksToBcd(input longint t);
    longint ms_total;
    ms_total = t / 100000;
    return packTime(int'(ms_total / 60000), int'((ms_total / 1000) % 60), int'(ms_total % 1000));
  endfunction

  task automatic checkVal(input string name, input longint got, input longint expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, expv);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] t, input longint et, input bit ee, input bit eo);
    exp_t e;
    e.ticks = et;
    e.err = ee;
    e.ovf = eo;
    e.lat = ee ? 1 : 12;
    e.start_cyc = cyc + 1;
    sb.push_back(e);
    time_bcd = t;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    time_bcd = $urandom;
  endtask

  task automatic checkOutput(input exp_t e);
    checkVal("ticks_out", longint'(ticks_out), e.ticks);
    checkVal("err", longint'(err), longint'(e.err));
    checkVal("ovf", longint'(ovf), longint'(e.ovf));
    checkVal("latency", cyc - e.start_cyc, longint'(e.lat));
  endtask

  task automatic waitDone(input int budget, output int busy_cnt);
    exp_t e;
    busy_cnt = 0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done: got done=1 with empty scoreboard, expected none");
        end else begin
          e = sb.pop_front();
          checkOutput(e);
        end
        return;
      end
      if (busy) busy_cnt++;
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("[TB] FAIL done_timeout: got no done within %0d cycles, expected done=1", budget);
    if (sb.size() != 0) void'(sb.pop_front());
  endtask

  task automatic runVector(input vec_t v);
    int bc;
    applyStimulus(v.t, v.ticks, v.err, v.ovf);
    waitDone(40, bc);
    checkVal("busy_cycles", longint'(bc), v.err ? 0 : 12);
    @(negedge clk);
    checkVal("done_width", longint'(done), 0);
    checkVal("ticks_hold", longint'(ticks_out), v.ticks);
  endtask

  initial begin
    int bc;
    int dc0;
    longint first_done;
    vec_t v;

    vecs[0]  = '{32'h0010_2003, 64'd6_200_300_000,   1'b0, 1'b0};
    vecs[1]  = '{32'h0000_0000, 64'd0,               1'b0, 1'b0};
    vecs[2]  = '{32'h0913_7558, 64'd549_755_800_000, 1'b0, 1'b0};
    vecs[3]  = '{32'h0913_7559, MAX_TICKS,           1'b0, 1'b1};
    vecs[4]  = '{32'h0006_0000, 64'd0,               1'b1, 1'b0};
    vecs[5]  = '{32'h0995_9999, MAX_TICKS,           1'b0, 1'b1};
    vecs[6]  = '{32'h0000_000A, 64'd0,               1'b1, 1'b0};
    vecs[7]  = '{32'h0000_0001, 64'd100_000,         1'b0, 1'b0};
    vecs[8]  = '{32'h0123_4567, 64'd75_456_700_000,  1'b0, 1'b0};
    vecs[9]  = '{32'h0000_A000, 64'd0,               1'b1, 1'b0};
    vecs[10] = '{32'h0055_9999, 64'd35_999_900_000,  1'b0, 1'b0};
    vecs[11] = '{32'h0A00_0000, 64'd0,               1'b1, 1'b0};
    vecs[12] = '{32'h0100_0000, 64'd60_000_000_000,  1'b0, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    time_bcd = '0;
    repeat (2) @(negedge clk);
    checkVal("reset_busy", longint'(busy), 0);
    checkVal("reset_done", longint'(done), 0);
    checkVal("reset_ticks", longint'(ticks_out), 0);
    checkVal("reset_err", longint'(err), 0);
    checkVal("reset_ovf", longint'(ovf), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) runVector(vecs[i]);

    // Back-to-back: second start issued in the cycle done is high.
    applyStimulus(32'h0000_0000, 0, 1'b0, 1'b0);
    waitDone(40, bc);
    first_done = cyc;
    applyStimulus(32'h0010_2003, 64'd6_200_300_000, 1'b0, 1'b0);
    waitDone(40, bc);
    checkVal("b2b_spacing", cyc - first_done, 13);
    @(negedge clk);

    // A start raised mid-conversion must be ignored.
    applyStimulus(32'h0123_4567, 64'd75_456_700_000, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    dc0 = done_count;
    time_bcd = 32'h0010_2003;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(40, bc);
    repeat (20) @(negedge clk);
    checkVal("ignored_start_dones", longint'(done_count - dc0), 1);

    // Asynchronous reset in the middle of a conversion.
    applyStimulus(32'h0010_2003, 64'd6_200_300_000, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkVal("midrun_reset_busy", longint'(busy), 0);
    checkVal("midrun_reset_done", longint'(done), 0);
    checkVal("midrun_reset_ticks", longint'(ticks_out), 0);
    checkVal("midrun_reset_err", longint'(err), 0);
    checkVal("midrun_reset_ovf", longint'(ovf), 0);
    sb.delete();
    dc0 = done_count;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    checkVal("no_done_after_reset", longint'(done_count - dc0), 0);
    runVector(vecs[0]);

    // Random valid times through the display-path model must round-trip.
    for (int i = 0; i < 8; i++) begin
      v.t = packTime(int'($urandom_range(0, 90)), int'($urandom_range(0, 59)),
                     int'($urandom_range(0, 999)));
      refModel(v.t, v.ticks, v.err, v.ovf);
      runVector(v);
      checkVal("round_trip", longint'(ticksToBcd(longint'(ticks_out))), longint'(v.t));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
